// File: rtl/rect_layer_multi_pkg.sv
// Shared constants and types for the multi-rectangle overlay layer.
// Counter widths, coordinate width, pipeline depth and frame-boundary test.
package rect_layer_multi_pkg;

   localparam int COORD_W    = 16;
   localparam int HCNT_W     = 11;
   localparam int VCNT_W     = 10;
   localparam int PIPE_DEPTH = 2;

   // The frame boundary is the first pixel of the first blanking line.
   localparam logic [HCNT_W-1:0] BOUNDARY_HST = 11'd0;

   typedef struct packed {
      logic [COORD_W-1:0] posx;
      logic [COORD_W-1:0] posy;
      logic [COORD_W-1:0] sizex;
      logic [COORD_W-1:0] sizey;
   } rect_geom_t;

   function automatic logic is_boundary(input logic [HCNT_W-1:0] hst,
                                        input logic [VCNT_W-1:0] vst,
                                        input logic [VCNT_W-1:0] height);
      return (hst == BOUNDARY_HST) && (vst == height);
   endfunction

endpackage

// File: rtl/rect_layer_multi_hit_test.sv
// Combinational coverage test of one pixel against one rectangle.
// Arithmetic is one bit wider than the coordinates so the far edge never wraps.
module rect_hit_test
   import rect_layer_multi_pkg::*;
(
   input  logic [HCNT_W-1:0] hst,
   input  logic [VCNT_W-1:0] vst,
   input  rect_geom_t        geom,
   output logic              hit
);

   logic [COORD_W:0] hx_s;
   logic [COORD_W:0] vy_s;
   logic [COORD_W:0] x0_s;
   logic [COORD_W:0] y0_s;
   logic [COORD_W:0] x1_s;
   logic [COORD_W:0] y1_s;

   assign hx_s = {{(COORD_W + 1 - HCNT_W){1'b0}}, hst};
   assign vy_s = {{(COORD_W + 1 - VCNT_W){1'b0}}, vst};
   assign x0_s = {1'b0, geom.posx};
   assign y0_s = {1'b0, geom.posy};
   assign x1_s = x0_s + {1'b0, geom.sizex};
   assign y1_s = y0_s + {1'b0, geom.sizey};

   // Inclusive start, exclusive end: a zero size can never satisfy both bounds.
   assign hit = (hx_s >= x0_s) && (hx_s < x1_s) && (vy_s >= y0_s) && (vy_s < y1_s);

endmodule

// File: rtl/rect_layer_multi.sv
// Paints up to NUM_RECTS prioritised filled rectangles over the incoming pixel stream,
// with frame-synchronous double-buffered configuration and a per-frame collision flag.
module rect_layer_multi
   import rect_layer_multi_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 800,
   parameter int SCREEN_HEIGHT = 600,
   parameter int NUM_RECTS     = 4,
   parameter int COLOR_W       = 3,
   parameter int IDX_W         = 2
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [HCNT_W-1:0]    hst,
   input  logic [VCNT_W-1:0]    vst,
   input  logic [COLOR_W-1:0]   rgb_i,
   input  logic                 cfg_wr,
   input  logic [IDX_W-1:0]     cfg_idx,
   input  logic [COORD_W-1:0]   cfg_posx,
   input  logic [COORD_W-1:0]   cfg_posy,
   input  logic [COORD_W-1:0]   cfg_sizex,
   input  logic [COORD_W-1:0]   cfg_sizey,
   input  logic [COLOR_W-1:0]   cfg_color,
   output logic [COLOR_W-1:0]   rgb_o,
   output logic [NUM_RECTS-1:0] hit_o,
   output logic                 collision_o,
   output logic                 frame_tick_o,
   output logic                 cfg_pending_o
);

   localparam logic [HCNT_W-1:0] SCREEN_W_C = HCNT_W'(SCREEN_WIDTH);
   localparam logic [VCNT_W-1:0] SCREEN_H_C = VCNT_W'(SCREEN_HEIGHT);

   rect_geom_t           pend_geom_r  [NUM_RECTS];
   logic [COLOR_W-1:0]   pend_color_r [NUM_RECTS];
   rect_geom_t           act_geom_r   [NUM_RECTS];
   logic [COLOR_W-1:0]   act_color_r  [NUM_RECTS];
   logic [NUM_RECTS-1:0] dirty_r;
   logic [NUM_RECTS-1:0] dirty_nxt_s;
   logic [NUM_RECTS-1:0] wr_sel_s;

   logic                 boundary_s;
   logic                 vis_s;
   logic [NUM_RECTS-1:0] hit_s;
   logic [NUM_RECTS-1:0] hit1_r;
   logic                 vis1_r;
   logic [COLOR_W-1:0]   rgb1_r;
   logic [COLOR_W-1:0]   mux_color_s;
   logic                 others_s;
   logic                 coll1_s;
   logic                 sticky_r;

   assign boundary_s = is_boundary(hst, vst, SCREEN_H_C);
   assign vis_s      = (hst < SCREEN_W_C) && (vst < SCREEN_H_C);

   // Decode the write strobe; out-of-range indices select no slot.
   always_comb begin
      wr_sel_s = '0;
      for (int i = 0; i < NUM_RECTS; i++) begin
         if (cfg_wr && (32'(cfg_idx) == i)) begin
            wr_sel_s[i] = 1'b1;
         end else begin
            wr_sel_s[i] = 1'b0;
         end
      end
   end

   // A write on the boundary cycle keeps its slot dirty for the next frame.
   always_comb begin
      dirty_nxt_s = dirty_r;
      for (int i = 0; i < NUM_RECTS; i++) begin
         if (wr_sel_s[i]) begin
            dirty_nxt_s[i] = 1'b1;
         end else if (boundary_s) begin
            dirty_nxt_s[i] = 1'b0;
         end else begin
            dirty_nxt_s[i] = dirty_r[i];
         end
      end
   end

   // Pending/active shadow registers; active reads the pre-write pending value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_RECTS; i++) begin
            pend_geom_r[i]  <= '0;
            pend_color_r[i] <= '0;
            act_geom_r[i]   <= '0;
            act_color_r[i]  <= '0;
         end
         dirty_r <= '0;
      end else begin
         for (int i = 0; i < NUM_RECTS; i++) begin
            if (wr_sel_s[i]) begin
               pend_geom_r[i]  <= '{posx: cfg_posx, posy: cfg_posy,
                                    sizex: cfg_sizex, sizey: cfg_sizey};
               pend_color_r[i] <= cfg_color;
            end
            if (boundary_s && dirty_r[i]) begin
               act_geom_r[i]  <= pend_geom_r[i];
               act_color_r[i] <= pend_color_r[i];
            end
         end
         dirty_r <= dirty_nxt_s;
      end
   end

   for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
      rect_hit_test u_hit (
         .hst  (hst),
         .vst  (vst),
         .geom (act_geom_r[g]),
         .hit  (hit_s[g])
      );
   end

   // Stage 1: capture hit vector, visibility and the upstream colour.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit1_r <= '0;
         vis1_r <= 1'b0;
         rgb1_r <= '0;
      end else begin
         hit1_r <= hit_s;
         vis1_r <= vis_s;
         rgb1_r <= rgb_i;
      end
   end

   // Walk from the highest index down so the lowest hit index wins.
   always_comb begin
      mux_color_s = rgb1_r;
      for (int i = NUM_RECTS - 1; i >= 0; i--) begin
         if (hit1_r[i]) begin
            mux_color_s = act_color_r[i];
         end else begin
            mux_color_s = mux_color_s;
         end
      end
   end

   // Stage 2: blank outside the visible area.
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_o <= '0;
         hit_o <= '0;
      end else begin
         rgb_o <= vis1_r ? mux_color_s : '0;
         hit_o <= hit1_r & {NUM_RECTS{vis1_r}};
      end
   end

   // Rect 0 colliding with any other rect on a visible stage-1 result.
   always_comb begin
      others_s = 1'b0;
      for (int i = 1; i < NUM_RECTS; i++) begin
         others_s = others_s | hit1_r[i];
      end
      coll1_s = vis1_r && hit1_r[0] && others_s;
   end

   // Sticky collision is published and restarted at the boundary; in-flight hits go to the new frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_r    <= 1'b0;
         collision_o <= 1'b0;
      end else if (boundary_s) begin
         collision_o <= sticky_r;
         sticky_r    <= coll1_s;
      end else if (coll1_s) begin
         sticky_r    <= 1'b1;
      end
   end

   // Frame tick and pending flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_tick_o  <= 1'b0;
         cfg_pending_o <= 1'b0;
      end else begin
         frame_tick_o  <= boundary_s;
         cfg_pending_o <= |dirty_nxt_s;
      end
   end

endmodule

// File: tb/tb_rect_layer_multi.sv
// Directed, table-driven bench for rect_layer_multi (800x600, 4 rects, 3-bit colour).
module tb_rect_layer_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hst;
   logic [9:0]  vst;
   logic [2:0]  rgb_i;
   logic        cfg_wr;
   logic [2:0]  cfg_idx;
   logic [15:0] cfg_posx, cfg_posy, cfg_sizex, cfg_sizey;
   logic [2:0]  cfg_color;
   logic [2:0]  rgb_o;
   logic [3:0]  hit_o;
   logic        collision_o, frame_tick_o, cfg_pending_o;

   int n_checks  = 0;
   int n_errors  = 0;
   int tick_cnt  = 0;
   int exp_ticks = 0;

   typedef struct {
      int         phase;
      int         h;
      int         v;
      logic [2:0] rgb;
      logic [3:0] hit;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (frame_tick_o === 1'b1) tick_cnt <= tick_cnt + 1;
   end

   rect_layer_multi #(
      .SCREEN_WIDTH(800), .SCREEN_HEIGHT(600), .NUM_RECTS(4), .COLOR_W(3), .IDX_W(3)
   ) dut (
      .clk(clk), .rst(rst), .hst(hst), .vst(vst), .rgb_i(rgb_i),
      .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_posx(cfg_posx), .cfg_posy(cfg_posy),
      .cfg_sizex(cfg_sizex), .cfg_sizey(cfg_sizey), .cfg_color(cfg_color),
      .rgb_o(rgb_o), .hit_o(hit_o), .collision_o(collision_o),
      .frame_tick_o(frame_tick_o), .cfg_pending_o(cfg_pending_o)
   );

   function automatic void add(input int p, input int h, input int v,
                               input logic [2:0] r, input logic [3:0] hh);
      vec_t e;
      e.phase = p; e.h = h; e.v = v; e.rgb = r; e.hit = hh;
      vecs.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int h, input int v);
      hst = 11'(h);
      vst = 10'(v);
   endtask

   // Present one pixel and check the result two cycles later.
   task automatic check_pix(input string name, input int h, input int v,
                            input logic [2:0] r, input logic [3:0] hh);
      drive(h, v);
      tick();
      tick();
      chk({name, ".rgb"}, 32'(rgb_o), 32'(r));
      chk({name, ".hit"}, 32'(hit_o), 32'(hh));
   endtask

   task automatic run_phase(input int p);
      foreach (vecs[k]) begin
         if (vecs[k].phase == p) begin
            check_pix($sformatf("p%0d(%0d,%0d)", p, vecs[k].h, vecs[k].v),
                      vecs[k].h, vecs[k].v, vecs[k].rgb, vecs[k].hit);
         end
      end
   endtask

   task automatic set_cfg(input int idx, input int px, input int py,
                          input int sx, input int sy, input int col);
      cfg_idx   = 3'(idx);
      cfg_posx  = 16'(px);
      cfg_posy  = 16'(py);
      cfg_sizex = 16'(sx);
      cfg_sizey = 16'(sy);
      cfg_color = 3'(col);
   endtask

   task automatic cfg_write(input int idx, input int px, input int py,
                            input int sx, input int sy, input int col);
      drive(900, 0);
      set_cfg(idx, px, py, sx, sy, col);
      cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0;
   endtask

   // Flush the pipe with blanking, then present exactly one boundary cycle.
   task automatic boundary(input bit with_wr);
      drive(900, 600);
      tick();
      tick();
      drive(0, 600);
      cfg_wr = with_wr;
      tick();
      cfg_wr = 1'b0;
      exp_ticks++;
      chk("tick_high", 32'(frame_tick_o), 32'd1);
      drive(1, 600);
      tick();
      chk("tick_low", 32'(frame_tick_o), 32'd0);
   endtask

   initial begin
      rst = 1'b1; rgb_i = 3'b010; cfg_wr = 1'b0;
      drive(900, 0);
      set_cfg(0, 0, 0, 0, 0, 0);

      // phase 0: defaults
      add(0, 0, 0, 3'b010, 4'b0000);
      add(0, 799, 599, 3'b010, 4'b0000);
      add(0, 800, 0, 3'b000, 4'b0000);
      add(0, 5, 600, 3'b000, 4'b0000);
      add(0, 100, 50, 3'b010, 4'b0000);
      // phase 1: rect0 (100,50) 10x5 colour 4
      add(1, 100, 50, 3'b100, 4'b0001);
      add(1, 109, 54, 3'b100, 4'b0001);
      add(1, 110, 54, 3'b010, 4'b0000);
      add(1, 109, 55, 3'b010, 4'b0000);
      add(1, 99, 50, 3'b010, 4'b0000);
      add(1, 100, 49, 3'b010, 4'b0000);
      // phase 2: rect0 (10,10,20,20) c1 over rect2 (20,20,20,20) c6
      add(2, 25, 25, 3'b001, 4'b0101);
      add(2, 35, 35, 3'b110, 4'b0100);
      add(2, 15, 15, 3'b001, 4'b0001);
      add(2, 29, 29, 3'b001, 4'b0101);
      add(2, 30, 30, 3'b110, 4'b0100);
      // phase 3: rect2 moved to (200,200)
      add(3, 25, 25, 3'b001, 4'b0001);
      add(3, 205, 205, 3'b110, 4'b0100);
      // phase 4: ignored index, zero-size rect1, rect3 clipped at the right edge
      add(4, 0, 0, 3'b010, 4'b0000);
      add(4, 5, 5, 3'b010, 4'b0000);
      add(4, 799, 5, 3'b011, 4'b1000);
      add(4, 795, 5, 3'b011, 4'b1000);
      add(4, 794, 5, 3'b010, 4'b0000);
      add(4, 800, 5, 3'b000, 4'b0000);
      add(4, 15, 15, 3'b001, 4'b0001);
      // phase 5/6: boundary race on rect1
      add(5, 305, 305, 3'b101, 4'b0010);
      add(5, 405, 405, 3'b010, 4'b0000);
      add(6, 405, 405, 3'b010, 4'b0010);
      add(6, 305, 305, 3'b010, 4'b0000);

      repeat (3) tick();
      chk("rst_rgb", 32'(rgb_o), 32'd0);
      chk("rst_hit", 32'(hit_o), 32'd0);
      chk("rst_coll", 32'(collision_o), 32'd0);
      chk("rst_tick", 32'(frame_tick_o), 32'd0);
      chk("rst_pend", 32'(cfg_pending_o), 32'd0);
      rst = 1'b0;

      run_phase(0);

      cfg_write(0, 100, 50, 10, 5, 4);
      chk("pend_set", 32'(cfg_pending_o), 32'd1);
      check_pix("mid_frame_hold", 100, 50, 3'b010, 4'b0000);
      chk("pend_hold", 32'(cfg_pending_o), 32'd1);
      boundary(1'b0);
      chk("pend_clr", 32'(cfg_pending_o), 32'd0);
      run_phase(1);

      // streaming alignment: 99, 100, 101, 110 on line 52
      drive(99, 52);  tick();
      drive(100, 52); tick();
      drive(101, 52); chk("stream0", 32'(rgb_o), 32'(3'b010)); tick();
      drive(110, 52); chk("stream1", 32'(rgb_o), 32'(3'b100)); tick();
      chk("stream2", 32'(rgb_o), 32'(3'b100)); tick();
      chk("stream3", 32'(rgb_o), 32'(3'b010));

      cfg_write(0, 10, 10, 20, 20, 1);
      cfg_write(2, 20, 20, 20, 20, 6);
      boundary(1'b0);
      chk("coll_none", 32'(collision_o), 32'd0);
      run_phase(2);
      cfg_write(2, 200, 200, 20, 20, 6);
      boundary(1'b0);
      chk("coll_set", 32'(collision_o), 32'd1);
      run_phase(3);
      boundary(1'b0);
      chk("coll_clr", 32'(collision_o), 32'd0);

      cfg_write(7, 0, 0, 800, 600, 7);
      chk("idx7_ignored", 32'(cfg_pending_o), 32'd0);
      cfg_write(1, 0, 0, 0, 600, 5);
      cfg_write(3, 795, 0, 100, 10, 3);
      boundary(1'b0);
      run_phase(4);

      cfg_write(1, 300, 300, 10, 10, 5);
      set_cfg(1, 400, 400, 10, 10, 2);
      boundary(1'b1);
      chk("race_pend", 32'(cfg_pending_o), 32'd1);
      run_phase(5);
      boundary(1'b0);
      chk("race_pend_clr", 32'(cfg_pending_o), 32'd0);
      run_phase(6);
      chk("tick_count", 32'(tick_cnt), 32'(exp_ticks));

      // mid-frame reset
      cfg_write(0, 500, 500, 5, 5, 7);
      chk("pre_rst_pend", 32'(cfg_pending_o), 32'd1);
      check_pix("pre_rst", 405, 405, 3'b010, 4'b0010);
      drive(400, 300);
      rst = 1'b1;
      tick();
      chk("mrst_rgb", 32'(rgb_o), 32'd0);
      chk("mrst_hit", 32'(hit_o), 32'd0);
      chk("mrst_coll", 32'(collision_o), 32'd0);
      chk("mrst_pend", 32'(cfg_pending_o), 32'd0);
      rst = 1'b0;
      drive(405, 405);
      tick();
      chk("mrst_hold", 32'(rgb_o), 32'd0);
      tick();
      chk("mrst_rect1_off", 32'(rgb_o), 32'(3'b010));
      check_pix("mrst_rect0_off", 15, 15, 3'b010, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rect_layer_multi.md
Name: rect_layer_multi

Overview:
- Parametrised successor to the single-rectangle painter in the VGA game overlay chain.
- Draws up to NUM_RECTS filled rectangles over the incoming pixel colour, with fixed priority (index 0 on top).
- Position/size/colour updates are double-buffered and take effect only at the frame boundary, so no tearing.
- Sits between the background/pattern stage and the VGA output stage; adds a registered pipeline, a per-frame collision flag and a frame tick for game logic.

Parameters:
- SCREEN_WIDTH, 800, visible pixels per line.
- SCREEN_HEIGHT, 600, visible lines per frame.
- NUM_RECTS, 4, number of rectangles (1..16).
- COLOR_W, 3, bits per pixel colour.
- IDX_W, 2, width of cfg_idx; must be >= clog2(NUM_RECTS), minimum 1.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- hst  in  11  horizontal counter of the current pixel.
- vst  in  10  vertical counter of the current pixel.
- rgb_i  in  COLOR_W  colour from the upstream stage, aligned with hst/vst.
- cfg_wr  in  1  one-cycle strobe; writes the cfg_* fields into the pending slot cfg_idx.
- cfg_idx  in  IDX_W  rectangle index; writes with cfg_idx >= NUM_RECTS are ignored.
- cfg_posx  in  16  left edge.
- cfg_posy  in  16  top edge.
- cfg_sizex  in  16  width; 0 disables the rectangle.
- cfg_sizey  in  16  height; 0 disables the rectangle.
- cfg_color  in  COLOR_W  fill colour.
- rgb_o  out  COLOR_W  output colour, 2-cycle latency.
- hit_o  out  NUM_RECTS  per-rectangle coverage of the pixel in rgb_o, aligned with rgb_o.
- collision_o  out  1  rect 0 overlapped any other rect in the previous frame.
- frame_tick_o  out  1  one-cycle pulse at the frame boundary.
- cfg_pending_o  out  1  at least one pending write not yet applied.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - rgb_o=0, hit_o=0, collision_o=0, frame_tick_o=0, cfg_pending_o=0.
  - All pending and active slots cleared (size 0, so disabled); sticky collision cleared.
  - Pipeline registers cleared.
  - Reset during an active frame takes effect on the next edge; output stays 0 until 2 cycles after rst falls.
- Hit test (per rect i, stage 1):
  - Condition: posx <= hst < posx+sizex AND posy <= vst < posy+sizey.
  - Sums computed at 17 bits so no wrap; e.g. posx=0xFFF0, sizex=0x20 covers up to 0x1000F.
  - Bounds are inclusive-start, exclusive-end, so a 1x1 rect covers exactly one pixel.
- Stage 1 registers: hit vector, visible = (hst<SCREEN_WIDTH && vst<SCREEN_HEIGHT), and rgb_i.
- Stage 2 registers:
  - rgb_o = 0 if not visible.
  - Otherwise cfg_color of the lowest-index hit rect, or the delayed rgb_i if no hit.
  - hit_o = hit vector masked by visible.
- Latency: rgb_o and hit_o reflect the hst/vst/rgb_i presented 2 cycles earlier.
- Config path:
  - cfg_wr with a valid index writes the pending slot and sets that slot's dirty bit.
  - Repeated writes to the same slot before the boundary: the last write wins.
  - cfg_pending_o = OR of all dirty bits.
- Frame boundary: the cycle where hst==0 && vst==SCREEN_HEIGHT (first blanking line). On that cycle:
  - Every dirty slot is copied pending -> active and its dirty bit cleared.
  - frame_tick_o is 1 on the following cycle only.
  - collision_o <= sticky; sticky <= 0.
- cfg_wr on the boundary cycle: the write lands in pending and stays dirty. The active slot receives the pre-write pending value only if that slot was already dirty; the new value applies at the next boundary.
- Collision: during visible pixels, sticky sets when hit[0] and any hit[j>0] are set in the same stage-1 result. Stage-1 results still in flight at the boundary count toward the next frame.
- No handshake backpressure; hst/vst assumed to advance continuously from the timing generator.

Decomposition:
- Shared package (include file) holds:
  - COORD_W=16 and the 11/10-bit counter width constants.
  - A localparam for pipeline depth (2).
  - The frame-boundary condition constant.
- Natural sub-module: rect_hit_test. One instance per rectangle via generate; purely combinational 17-bit compare producing a hit bit.
- Priority mux, shadow registers and collision logic stay in the top module.

Test Plan:
- Reset/defaults: rst for 3 cycles, sweep a frame with rgb_i=3'b010 -> rgb_o=3'b010 on visible pixels, 0 outside, hit_o=0, collision_o=0.
- Buffered update and bounds:
  - Write rect0 pos(100,50) size(10,5) colour 3'b100 mid-frame -> no change until the boundary; cfg_pending_o=1 until then.
  - Next frame: rgb_o=3'b100 exactly for hst 100..109, vst 50..54, 2 cycles after the matching hst/vst.
- Priority and collision:
  - Rect0 at (10,10,20,20) colour 1; rect2 at (20,20,20,20) colour 6.
  - Overlap pixel (25,25) -> rgb_o=1 and hit_o=4'b0101.
  - collision_o=1 after the following boundary; it clears one frame after rect2 is moved away.
- Edge cases:
  - cfg_idx=7 with NUM_RECTS=4 -> ignored.
  - sizex=0 -> rect never drawn.
  - posx=795, sizex=100 -> drawn only to hst 799, black from 800.
- Boundary race: cfg_wr on the boundary cycle -> cfg_pending_o stays 1; the value applies one frame later. Check that frame_tick_o pulses exactly once per frame.
- Mid-frame reset: assert rst at (400,300) -> rgb_o=0 on the next cycle, all rects disabled, collision_o=0.
